pipelined_control_unit: RTL and testbench
=========================================

Name: pipelined_control_unit

Overview:
- Next-generation RV32I control unit: decodes the instruction in ID and registers the full control bundle into an ID/EX control register.
- Detects load-use hazards and stalls for a parametrised number of cycles.
- Inserts bubbles on a flush from branch/jump resolution in EX.
- Adds all six branch conditions, byte/half/word signed/unsigned memory access, AUIPC/LUI, XOR/shift/SLTU ALU ops, and illegal-opcode flagging.

Parameters:
- LOAD_LATENCY, 1, number of bubbles inserted per load-use hazard (1..3)
- HAZARD_EN, 1, 0 disables hazard detection (stall_o tied 0)
- ALU_CTRL_W, 4, width of alu_ctrl_o (minimum 4)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- instr_i  in  32  instruction in ID
- instr_valid_i  in  1  instr_i is valid
- flush_i  in  1  EX resolved taken branch/jump; discard ID instruction
- stall_o  out  1  hold PC and IF/ID register this cycle
- valid_o  out  1  EX control bundle valid
- illegal_o  out  1  registered: unsupported opcode/funct
- reg_write_o, mem_write_o, mem_read_o, branch_o, jump_o, jalr_o, alu_src_o  out  1 each  registered controls
- result_src_o  out  2  0 ALU, 1 memory, 2 PC+4, 3 immediate
- alu_a_pc_o  out  1  ALU operand A = PC (AUIPC)
- branch_cond_o  out  3  funct3 of branch
- alu_ctrl_o  out  ALU_CTRL_W  ALU operation
- imm_src_o  out  3  0 I, 1 S, 2 B, 3 J, 4 U
- mem_size_o  out  2  0 byte, 1 half, 2 word
- mem_unsigned_o  out  1  zero-extend load
- rd_o, rs1_o, rs2_o  out  5 each  registered register indices

Behaviour:
- Reset (async, rst_n=0): every registered output is 0, FSM is RUN, stall counter is 0. stall_o is 0 while in reset.
- Decode is combinational from instr_i. The result is captured on the rising edge of clk: one cycle of latency, ID to EX.
- Bubble: all control outputs 0, valid_o=0, illegal_o=0, register indices 0.
- Edge priority:
  - flush_i=1: load bubble; FSM to RUN; counter cleared.
  - else stall_o=1: load bubble.
  - else: load the decoded bundle with valid_o=instr_valid_i.
- Hazard condition H, when HAZARD_EN=1 and FSM is RUN, requires all of:
  - valid_o=1 and mem_read_o=1 and rd_o≠0;
  - instr_valid_i=1;
  - rd_o equals a source the ID instruction actually reads: rs1 for I/S/B/R/JALR, rs2 for S/B/R only. Never for LUI, AUIPC or JAL.
- stall_o = !flush_i && (H || state==STALL).
- FSM RUN→STALL:
  - on H && !flush_i && LOAD_LATENCY>1;
  - counter loaded with LOAD_LATENCY-1.
- FSM STALL:
  - counter decrements each cycle;
  - returns to RUN when the counter reaches 1 at the edge.
  - Total bubbles per hazard = LOAD_LATENCY.
- Back-to-back loads: a second hazard after the stall releases starts a fresh stall.
- Illegal opcode/funct: bundle as bubble but valid_o=instr_valid_i, illegal_o=1.
- ALU encoding: ADD 0, SUB 1, AND 2, OR 3, SLL 4, SLT 5, PASSB 6, XOR 7, SRL 8, SRA 9, SLTU 10. Upper bits are 0 when ALU_CTRL_W>4.
- Opcode decode:
  - R-type: SUB when funct7[5]=1 and funct3=000; SRA when funct7[5]=1 and funct3=101.
  - I-ALU: SRAI when funct7[5]=1 and funct3=101. funct7[5] is otherwise ignored for I-ALU.
  - Load/store: ALU=ADD; mem_size_o=funct3[1:0]; mem_unsigned_o=funct3[2] for loads.
  - Illegal memory sizes: funct3 011/110/111 for loads, and stores with funct3[2]=1.
  - Branch: ALU=SUB, branch_cond_o=funct3. funct3 010/011 is illegal.
  - JAL/JALR: result_src_o=2.
  - LUI: result_src_o=3.
  - AUIPC: alu_a_pc_o=1, alu_src_o=1, ALU=ADD.

Decomposition:
- ctrl_pkg: opcode localparams, alu_op_e enum, imm_src_e, result_src_e, mem_size_e, and a packed ctrl_bundle_t struct.
- One sub-module, ctrl_decoder: purely combinational, instr to ctrl_bundle_t plus reads_rs1/reads_rs2/illegal.
- Top level holds the ID/EX register, hazard comparator and stall FSM/counter.

Test Plan:
- Reset mid-stream: assert rst_n=0 while in STALL → all outputs 0 immediately; after release, the first instruction `add x3,x1,x2` gives alu_ctrl_o=0, reg_write_o=1, valid_o=1 one cycle later.
- LOAD_LATENCY=1: `lw x5,0(x1)` then `add x6,x5,x2` → stall_o=1 for exactly 1 cycle, one bubble, then add issues with rs1_o=5.
- LOAD_LATENCY=3: the same pair → stall_o high for 3 cycles, 3 bubbles.
- No-hazard cases:
  - `lw x0`, then a reader of x0 → stall_o=0.
  - `lw x5`, then `lui x5` → stall_o=0.
- flush_i=1 during STALL cycle 2 → stall_o=0 that cycle, bubble loaded, FSM RUN.
- Decode sweep:
  - `bgeu` → branch_cond_o=7, alu_ctrl_o=1.
  - `lhu` → mem_size_o=1, mem_unsigned_o=1.
  - `srai` → alu_ctrl_o=9.
  - opcode 7'h7F → illegal_o=1, reg_write_o=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types for the RV32I ID-stage control unit: opcodes, control enums and the
// ID/EX control bundle.
package ctrl_pkg;

    localparam logic [6:0] OpLoad   = 7'h03;
    localparam logic [6:0] OpOpImm  = 7'h13;
    localparam logic [6:0] OpAuipc  = 7'h17;
    localparam logic [6:0] OpStore  = 7'h23;
    localparam logic [6:0] OpOp     = 7'h33;
    localparam logic [6:0] OpLui    = 7'h37;
    localparam logic [6:0] OpBranch = 7'h63;
    localparam logic [6:0] OpJalr   = 7'h67;
    localparam logic [6:0] OpJal    = 7'h6F;

    typedef enum logic [3:0] {
        AluAdd   = 4'd0,
        AluSub   = 4'd1,
        AluAnd   = 4'd2,
        AluOr    = 4'd3,
        AluSll   = 4'd4,
        AluSlt   = 4'd5,
        AluPassB = 4'd6,
        AluXor   = 4'd7,
        AluSrl   = 4'd8,
        AluSra   = 4'd9,
        AluSltu  = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {ImmI, ImmS, ImmB, ImmJ, ImmU} imm_src_e;
    typedef enum logic [1:0] {ResAlu, ResMem, ResPc4, ResImm} result_src_e;
    typedef enum logic [1:0] {MemByte, MemHalf, MemWord} mem_size_e;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        mem_read;
        logic        branch;
        logic        jump;
        logic        jalr;
        logic        alu_src;
        result_src_e result_src;
        logic        alu_a_pc;
        logic [2:0]  branch_cond;
        alu_op_e     alu_ctrl;
        imm_src_e    imm_src;
        mem_size_e   mem_size;
        logic        mem_unsigned;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } ctrl_bundle_t;

    // alt selects SUB (funct3 000) or SRA (funct3 101); callers mask it for I-type.
    function automatic alu_op_e alu_from_funct3(logic [2:0] funct3, logic alt);
        alu_op_e op;
        case (funct3)
            3'b000:  op = alt ? AluSub : AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluSlt;
            3'b011:  op = AluSltu;
            3'b100:  op = AluXor;
            3'b101:  op = alt ? AluSra : AluSrl;
            3'b110:  op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational RV32I decoder: instruction word to control bundle, source-use flags
// and an illegal flag. Illegal encodings decode to an all-zero bundle.
module ctrl_decoder
    import ctrl_pkg::*;
(
    input  logic [31:0]  instr_i,
    output ctrl_bundle_t ctrl_o,
    output logic         reads_rs1_o,
    output logic         reads_rs2_o,
    output logic         illegal_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       unused_bits;

    assign opcode      = instr_i[6:0];
    assign funct3      = instr_i[14:12];
    assign funct7_5    = instr_i[30];
    assign unused_bits = ^{instr_i[31], instr_i[29:25]};

    ctrl_bundle_t dec;
    logic         rd1;
    logic         rd2;
    logic         ill;

    always_comb begin
        dec     = '0;
        rd1     = 1'b0;
        rd2     = 1'b0;
        ill     = 1'b0;
        dec.rd  = instr_i[11:7];
        dec.rs1 = instr_i[19:15];
        dec.rs2 = instr_i[24:20];
        case (opcode)
            OpOp: begin
                dec.reg_write = 1'b1;
                dec.alu_ctrl  = alu_from_funct3(funct3, funct7_5);
                rd1           = 1'b1;
                rd2           = 1'b1;
            end
            OpOpImm: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_ctrl  = alu_from_funct3(funct3, funct7_5 && (funct3 == 3'b101));
                rd1           = 1'b1;
            end
            OpLoad: begin
                dec.reg_write    = 1'b1;
                dec.mem_read     = 1'b1;
                dec.alu_src      = 1'b1;
                dec.result_src   = ResMem;
                dec.mem_size     = mem_size_e'(funct3[1:0]);
                dec.mem_unsigned = funct3[2];
                rd1              = 1'b1;
                ill = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OpStore: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm_src   = ImmS;
                dec.mem_size  = mem_size_e'(funct3[1:0]);
                rd1           = 1'b1;
                rd2           = 1'b1;
                ill           = funct3[2];
            end
            OpBranch: begin
                dec.branch      = 1'b1;
                dec.alu_ctrl    = AluSub;
                dec.branch_cond = funct3;
                dec.imm_src     = ImmB;
                rd1             = 1'b1;
                rd2             = 1'b1;
                ill             = (funct3[2:1] == 2'b01);
            end
            OpJal: begin
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.result_src = ResPc4;
                dec.imm_src    = ImmJ;
            end
            OpJalr: begin
                dec.reg_write  = 1'b1;
                dec.jalr       = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = ResPc4;
                rd1            = 1'b1;
            end
            OpLui: begin
                dec.reg_write  = 1'b1;
                dec.result_src = ResImm;
                dec.imm_src    = ImmU;
            end
            OpAuipc: begin
                dec.reg_write = 1'b1;
                dec.alu_a_pc  = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm_src   = ImmU;
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            dec = '0;
            rd1 = 1'b0;
            rd2 = 1'b0;
        end
    end

    assign ctrl_o      = dec;
    assign reads_rs1_o = rd1;
    assign reads_rs2_o = rd2;
    assign illegal_o   = ill;

endmodule

// File: rtl/pipelined_control_unit.sv
// RV32I control unit: ID decode into an ID/EX control register, load-use hazard stall
// FSM and flush bubbles.
module pipelined_control_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned LOAD_LATENCY = 1,
    parameter int unsigned HAZARD_EN    = 1,
    parameter int unsigned ALU_CTRL_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           instr_i,
    input  logic                  instr_valid_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  valid_o,
    output logic                  illegal_o,
    output logic                  reg_write_o,
    output logic                  mem_write_o,
    output logic                  mem_read_o,
    output logic                  branch_o,
    output logic                  jump_o,
    output logic                  jalr_o,
    output logic                  alu_src_o,
    output logic [1:0]            result_src_o,
    output logic                  alu_a_pc_o,
    output logic [2:0]            branch_cond_o,
    output logic [ALU_CTRL_W-1:0] alu_ctrl_o,
    output logic [2:0]            imm_src_o,
    output logic [1:0]            mem_size_o,
    output logic                  mem_unsigned_o,
    output logic [4:0]            rd_o,
    output logic [4:0]            rs1_o,
    output logic [4:0]            rs2_o
);

    typedef enum logic {StRun, StStall} state_e;

    ctrl_bundle_t dec;
    logic         dec_rs1;
    logic         dec_rs2;
    logic         dec_illegal;

    ctrl_decoder u_decoder (
        .instr_i     (instr_i),
        .ctrl_o      (dec),
        .reads_rs1_o (dec_rs1),
        .reads_rs2_o (dec_rs2),
        .illegal_o   (dec_illegal)
    );

    ctrl_bundle_t ex_q;
    logic         valid_q;
    logic         illegal_q;
    state_e       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         hazard;
    logic         stall;

    always_comb begin
        hazard = (HAZARD_EN != 0) && (state_q == StRun) && valid_q && ex_q.mem_read
                 && (ex_q.rd != 5'd0) && instr_valid_i
                 && ((dec_rs1 && (dec.rs1 == ex_q.rd)) || (dec_rs2 && (dec.rs2 == ex_q.rd)));
        stall  = !flush_i && (hazard || (state_q == StStall));
    end

    // The hazard cycle is the first bubble; STALL covers the remaining LOAD_LATENCY-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            state_d = StRun;
            cnt_d   = '0;
        end else if (state_q == StRun) begin
            if (hazard && (LOAD_LATENCY > 1)) begin
                state_d = StStall;
                cnt_d   = 2'(LOAD_LATENCY - 1);
            end
        end else if (cnt_q == 2'd1) begin
            state_d = StRun;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StRun;
            cnt_q     <= '0;
            ex_q      <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (flush_i || stall) begin
                ex_q      <= '0;
                valid_q   <= 1'b0;
                illegal_q <= 1'b0;
            end else begin
                ex_q      <= dec;
                valid_q   <= instr_valid_i;
                illegal_q <= dec_illegal;
            end
        end
    end

    always_comb begin
        alu_ctrl_o      = '0;
        alu_ctrl_o[3:0] = ex_q.alu_ctrl;
    end

    assign stall_o        = stall;
    assign valid_o        = valid_q;
    assign illegal_o      = illegal_q;
    assign reg_write_o    = ex_q.reg_write;
    assign mem_write_o    = ex_q.mem_write;
    assign mem_read_o     = ex_q.mem_read;
    assign branch_o       = ex_q.branch;
    assign jump_o         = ex_q.jump;
    assign jalr_o         = ex_q.jalr;
    assign alu_src_o      = ex_q.alu_src;
    assign result_src_o   = ex_q.result_src;
    assign alu_a_pc_o     = ex_q.alu_a_pc;
    assign branch_cond_o  = ex_q.branch_cond;
    assign imm_src_o      = ex_q.imm_src;
    assign mem_size_o     = ex_q.mem_size;
    assign mem_unsigned_o = ex_q.mem_unsigned;
    assign rd_o           = ex_q.rd;
    assign rs1_o          = ex_q.rs1;
    assign rs2_o          = ex_q.rs2;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit: three instances (latency 1, latency 3,
// hazard detection off with a 6-bit ALU field) share one instruction stream.
module tb_pipelined_control_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        flush = 1'b0;
    int          checks = 0;
    int          failures = 0;

    localparam logic [31:0] LwX5     = 32'h0000A283;  // lw   x5,0(x1)
    localparam logic [31:0] AddX6X5  = 32'h00228333;  // add  x6,x5,x2
    localparam logic [31:0] AddX3    = 32'h002081B3;  // add  x3,x1,x2
    localparam logic [31:0] LwX0     = 32'h0000A003;  // lw   x0,0(x1)
    localparam logic [31:0] AddX6X0  = 32'h00200333;  // add  x6,x0,x2
    localparam logic [31:0] LuiX5    = 32'h123452B7;  // lui  x5,0x12345
    localparam logic [31:0] LwX7X5   = 32'h0002A383;  // lw   x7,0(x5)
    localparam logic [31:0] AddX8X7  = 32'h00238433;  // add  x8,x7,x2
    localparam logic [31:0] Bgeu     = 32'h0020F063;  // bgeu x1,x2,0
    localparam logic [31:0] Lhu      = 32'h0000D383;  // lhu  x7,0(x1)
    localparam logic [31:0] Srai     = 32'h4030D413;  // srai x8,x1,3
    localparam logic [31:0] Op7f     = 32'h0000007F;
    localparam logic [31:0] SubX3    = 32'h402081B3;  // sub  x3,x1,x2
    localparam logic [31:0] XorX3    = 32'h0020C1B3;  // xor  x3,x1,x2
    localparam logic [31:0] SltuX3   = 32'h0020B1B3;  // sltu x3,x1,x2
    localparam logic [31:0] Auipc    = 32'h00001217;  // auipc x4,1
    localparam logic [31:0] Sw       = 32'h0020A023;  // sw   x2,0(x1)
    localparam logic [31:0] LdIll    = 32'h0000B283;  // load funct3 011
    localparam logic [31:0] BrIll    = 32'h0020A063;  // branch funct3 010

    logic a_stall, a_valid, a_illegal, a_reg_write, a_mem_write, a_mem_read, a_branch;
    logic a_jump, a_jalr, a_alu_src, a_alu_a_pc, a_mem_unsigned;
    logic [1:0] a_result_src, a_mem_size;
    logic [2:0] a_branch_cond, a_imm_src;
    logic [3:0] a_alu;
    logic [4:0] a_rd, a_rs1, a_rs2;

    logic c_stall, c_valid, c_illegal, c_reg_write, c_mem_write, c_mem_read, c_branch;
    logic c_jump, c_jalr, c_alu_src, c_alu_a_pc, c_mem_unsigned;
    logic [1:0] c_result_src, c_mem_size;
    logic [2:0] c_branch_cond, c_imm_src;
    logic [3:0] c_alu;
    logic [4:0] c_rd, c_rs1, c_rs2;

    logic n_stall, n_valid, n_illegal, n_reg_write, n_mem_write, n_mem_read, n_branch;
    logic n_jump, n_jalr, n_alu_src, n_alu_a_pc, n_mem_unsigned;
    logic [1:0] n_result_src, n_mem_size;
    logic [2:0] n_branch_cond, n_imm_src;
    logic [5:0] n_alu;
    logic [4:0] n_rd, n_rs1, n_rs2;

    pipelined_control_unit #(.LOAD_LATENCY(1), .HAZARD_EN(1), .ALU_CTRL_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .instr_i(instr), .instr_valid_i(instr_valid),
        .flush_i(flush), .stall_o(a_stall), .valid_o(a_valid), .illegal_o(a_illegal),
        .reg_write_o(a_reg_write), .mem_write_o(a_mem_write), .mem_read_o(a_mem_read),
        .branch_o(a_branch), .jump_o(a_jump), .jalr_o(a_jalr), .alu_src_o(a_alu_src),
        .result_src_o(a_result_src), .alu_a_pc_o(a_alu_a_pc), .branch_cond_o(a_branch_cond),
        .alu_ctrl_o(a_alu), .imm_src_o(a_imm_src), .mem_size_o(a_mem_size),
        .mem_unsigned_o(a_mem_unsigned), .rd_o(a_rd), .rs1_o(a_rs1), .rs2_o(a_rs2)
    );

    pipelined_control_unit #(.LOAD_LATENCY(3), .HAZARD_EN(1), .ALU_CTRL_W(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .instr_i(instr), .instr_valid_i(instr_valid),
        .flush_i(flush), .stall_o(c_stall), .valid_o(c_valid), .illegal_o(c_illegal),
        .reg_write_o(c_reg_write), .mem_write_o(c_mem_write), .mem_read_o(c_mem_read),
        .branch_o(c_branch), .jump_o(c_jump), .jalr_o(c_jalr), .alu_src_o(c_alu_src),
        .result_src_o(c_result_src), .alu_a_pc_o(c_alu_a_pc), .branch_cond_o(c_branch_cond),
        .alu_ctrl_o(c_alu), .imm_src_o(c_imm_src), .mem_size_o(c_mem_size),
        .mem_unsigned_o(c_mem_unsigned), .rd_o(c_rd), .rs1_o(c_rs1), .rs2_o(c_rs2)
    );

    pipelined_control_unit #(.LOAD_LATENCY(2), .HAZARD_EN(0), .ALU_CTRL_W(6)) dutn (
        .clk(clk), .rst_n(rst_n), .instr_i(instr), .instr_valid_i(instr_valid),
        .flush_i(flush), .stall_o(n_stall), .valid_o(n_valid), .illegal_o(n_illegal),
        .reg_write_o(n_reg_write), .mem_write_o(n_mem_write), .mem_read_o(n_mem_read),
        .branch_o(n_branch), .jump_o(n_jump), .jalr_o(n_jalr), .alu_src_o(n_alu_src),
        .result_src_o(n_result_src), .alu_a_pc_o(n_alu_a_pc), .branch_cond_o(n_branch_cond),
        .alu_ctrl_o(n_alu), .imm_src_o(n_imm_src), .mem_size_o(n_mem_size),
        .mem_unsigned_o(n_mem_unsigned), .rd_o(n_rd), .rs1_o(n_rs1), .rs2_o(n_rs2)
    );

    always #5 clk = ~clk;

    // Inputs change 1 ns after the rising edge; checks follow 1 ns later.
    task automatic issue(input logic [31:0] ins, input logic v, input logic fl);
        @(posedge clk);
        #1;
        instr       = ins;
        instr_valid = v;
        flush       = fl;
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        instr       = '0;
        instr_valid = 1'b0;
        flush       = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Holds ins while the latency-3 instance stalls; counts stall cycles and bubbles.
    task automatic hold_while_stalled(input logic [31:0] ins, output int n, output int b);
        n = 0;
        b = 0;
        while (c_stall && n < 8) begin
            n++;
            issue(ins, 1'b1, 1'b0);
            if (!c_valid) b++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({a_stall, a_valid, a_illegal, a_reg_write, a_mem_read, a_alu, a_rd} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got %h want 0",
                     {a_stall, a_valid, a_illegal, a_reg_write, a_mem_read, a_alu, a_rd});
        end
        do_reset();
    endtask

    task automatic test_latency1();
        do_reset();
        issue(LwX5, 1'b1, 1'b0);
        checks++;
        if (a_stall !== 1'b0) begin failures++; $display("FAIL l1_no_stall_on_lw got %b want 0", a_stall); end
        issue(AddX6X5, 1'b1, 1'b0);
        checks++;
        if ({a_stall, a_valid, a_mem_read, a_rd} !== {1'b1, 1'b1, 1'b1, 5'd5}) begin
            failures++;
            $display("FAIL l1_hazard got %b%b%b rd=%0d want 111 rd=5", a_stall, a_valid, a_mem_read, a_rd);
        end
        issue(AddX6X5, 1'b1, 1'b0);
        checks++;
        if ({a_stall, a_valid} !== 2'b00) begin
            failures++;
            $display("FAIL l1_bubble stall/valid got %b%b want 00", a_stall, a_valid);
        end
        issue('0, 1'b0, 1'b0);
        checks++;
        if ({a_valid, a_reg_write, a_rs1, a_rd} !== {1'b1, 1'b1, 5'd5, 5'd6}) begin
            failures++;
            $display("FAIL l1_add_issue got v=%b rw=%b rs1=%0d rd=%0d want 1 1 5 6",
                     a_valid, a_reg_write, a_rs1, a_rd);
        end
    endtask

    task automatic test_latency3();
        int n, b;
        do_reset();
        issue(LwX5, 1'b1, 1'b0);
        issue(AddX6X5, 1'b1, 1'b0);
        hold_while_stalled(AddX6X5, n, b);
        checks++;
        if (n != 3) begin failures++; $display("FAIL l3_stall_cycles got %0d want 3", n); end
        checks++;
        if (b != 3) begin failures++; $display("FAIL l3_bubbles got %0d want 3", b); end
        issue('0, 1'b0, 1'b0);
        checks++;
        if ({c_valid, c_rs1} !== {1'b1, 5'd5}) begin
            failures++;
            $display("FAIL l3_add_issue got v=%b rs1=%0d want 1 5", c_valid, c_rs1);
        end
    endtask

    task automatic test_back_to_back();
        int n, b;
        do_reset();
        issue(LwX5, 1'b1, 1'b0);
        issue(LwX7X5, 1'b1, 1'b0);
        hold_while_stalled(LwX7X5, n, b);
        checks++;
        if (n != 3) begin failures++; $display("FAIL b2b_first_stall got %0d want 3", n); end
        issue(AddX8X7, 1'b1, 1'b0);
        checks++;
        if ({c_valid, c_mem_read, c_rd} !== {1'b1, 1'b1, 5'd7}) begin
            failures++;
            $display("FAIL b2b_second_load got v=%b mr=%b rd=%0d want 1 1 7", c_valid, c_mem_read, c_rd);
        end
        hold_while_stalled(AddX8X7, n, b);
        checks++;
        if (n != 3) begin failures++; $display("FAIL b2b_second_stall got %0d want 3", n); end
        issue('0, 1'b0, 1'b0);
        checks++;
        if ({c_valid, c_rs1, c_rd} !== {1'b1, 5'd7, 5'd8}) begin
            failures++;
            $display("FAIL b2b_add_issue got v=%b rs1=%0d rd=%0d want 1 7 8", c_valid, c_rs1, c_rd);
        end
    endtask

    task automatic test_no_hazard();
        do_reset();
        issue(LwX0, 1'b1, 1'b0);
        issue(AddX6X0, 1'b1, 1'b0);
        checks++;
        if ({a_stall, c_stall} !== 2'b00) begin
            failures++;
            $display("FAIL nh_lw_x0 stall got %b%b want 00", a_stall, c_stall);
        end
        issue(LwX5, 1'b1, 1'b0);
        issue(LuiX5, 1'b1, 1'b0);
        checks++;
        if ({a_stall, c_stall} !== 2'b00) begin
            failures++;
            $display("FAIL nh_lui stall got %b%b want 00", a_stall, c_stall);
        end
        issue(LwX5, 1'b1, 1'b0);
        checks++;
        if ({a_result_src, a_reg_write} !== {2'd3, 1'b1}) begin
            failures++;
            $display("FAIL lui_result_src got %0d rw=%b want 3 1", a_result_src, a_reg_write);
        end
        issue(AddX6X5, 1'b1, 1'b0);
        checks++;
        if ({a_stall, n_stall} !== 2'b10) begin
            failures++;
            $display("FAIL hazard_en0 stall got l1=%b off=%b want 1 0", a_stall, n_stall);
        end
    endtask

    task automatic test_flush();
        do_reset();
        issue(LwX5, 1'b1, 1'b0);
        issue(AddX6X5, 1'b1, 1'b0);
        checks++;
        if (c_stall !== 1'b1) begin failures++; $display("FAIL fl_stall1 got %b want 1", c_stall); end
        issue(AddX6X5, 1'b1, 1'b1);
        checks++;
        if (c_stall !== 1'b0) begin failures++; $display("FAIL fl_stall_masked got %b want 0", c_stall); end
        issue(AddX6X5, 1'b1, 1'b0);
        checks++;
        if ({c_stall, c_valid} !== 2'b00) begin
            failures++;
            $display("FAIL fl_back_to_run stall/valid got %b%b want 00", c_stall, c_valid);
        end
        issue('0, 1'b0, 1'b0);
        checks++;
        if ({c_valid, c_rd} !== {1'b1, 5'd6}) begin
            failures++;
            $display("FAIL fl_add_issue got v=%b rd=%0d want 1 6", c_valid, c_rd);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        issue(LwX5, 1'b1, 1'b0);
        issue(AddX6X5, 1'b1, 1'b0);
        issue(AddX6X5, 1'b1, 1'b0);
        checks++;
        if (c_stall !== 1'b1) begin failures++; $display("FAIL rm_in_stall got %b want 1", c_stall); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({c_stall, c_valid, c_mem_read, c_reg_write, c_rd} !== '0) begin
            failures++;
            $display("FAIL rm_async_clear got %b%b%b%b rd=%0d want 0000 rd=0",
                     c_stall, c_valid, c_mem_read, c_reg_write, c_rd);
        end
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        instr       = AddX3;
        instr_valid = 1'b1;
        #1;
        checks++;
        if (c_stall !== 1'b0) begin failures++; $display("FAIL rm_post_stall got %b want 0", c_stall); end
        issue('0, 1'b0, 1'b0);
        checks++;
        if ({c_valid, c_reg_write, c_alu, c_rd} !== {1'b1, 1'b1, 4'd0, 5'd3}) begin
            failures++;
            $display("FAIL rm_add_issue got v=%b rw=%b alu=%0d rd=%0d want 1 1 0 3",
                     c_valid, c_reg_write, c_alu, c_rd);
        end
    endtask

    task automatic test_decode();
        do_reset();
        issue(Bgeu, 1'b1, 1'b0);
        issue(Lhu, 1'b1, 1'b0);
        checks++;
        if ({a_branch, a_branch_cond, a_alu, a_imm_src} !== {1'b1, 3'd7, 4'd1, 3'd2}) begin
            failures++;
            $display("FAIL bgeu got br=%b cond=%0d alu=%0d imm=%0d want 1 7 1 2",
                     a_branch, a_branch_cond, a_alu, a_imm_src);
        end
        issue(Srai, 1'b1, 1'b0);
        checks++;
        if ({a_mem_read, a_mem_size, a_mem_unsigned, a_result_src} !== {1'b1, 2'd1, 1'b1, 2'd1}) begin
            failures++;
            $display("FAIL lhu got mr=%b size=%0d uns=%b res=%0d want 1 1 1 1",
                     a_mem_read, a_mem_size, a_mem_unsigned, a_result_src);
        end
        issue(Op7f, 1'b1, 1'b0);
        checks++;
        if ({a_alu, a_alu_src, n_alu} !== {4'd9, 1'b1, 6'd9}) begin
            failures++;
            $display("FAIL srai got alu=%0d src=%b alu6=%0d want 9 1 9", a_alu, a_alu_src, n_alu);
        end
        issue(SubX3, 1'b1, 1'b0);
        checks++;
        if ({a_illegal, a_valid, a_reg_write} !== 3'b110) begin
            failures++;
            $display("FAIL op7f got ill=%b v=%b rw=%b want 1 1 0", a_illegal, a_valid, a_reg_write);
        end
        issue(XorX3, 1'b1, 1'b0);
        checks++;
        if (a_alu !== 4'd1) begin failures++; $display("FAIL sub alu got %0d want 1", a_alu); end
        issue(SltuX3, 1'b1, 1'b0);
        checks++;
        if (a_alu !== 4'd7) begin failures++; $display("FAIL xor alu got %0d want 7", a_alu); end
        issue(Auipc, 1'b1, 1'b0);
        checks++;
        if (a_alu !== 4'd10) begin failures++; $display("FAIL sltu alu got %0d want 10", a_alu); end
        issue(Sw, 1'b1, 1'b0);
        checks++;
        if ({a_alu_a_pc, a_alu_src, a_alu, a_imm_src, a_rd} !== {1'b1, 1'b1, 4'd0, 3'd4, 5'd4}) begin
            failures++;
            $display("FAIL auipc got pc=%b src=%b alu=%0d imm=%0d rd=%0d want 1 1 0 4 4",
                     a_alu_a_pc, a_alu_src, a_alu, a_imm_src, a_rd);
        end
        issue(LdIll, 1'b1, 1'b0);
        checks++;
        if ({a_mem_write, a_mem_size, a_imm_src, a_reg_write} !== {1'b1, 2'd2, 3'd1, 1'b0}) begin
            failures++;
            $display("FAIL sw got mw=%b size=%0d imm=%0d rw=%b want 1 2 1 0",
                     a_mem_write, a_mem_size, a_imm_src, a_reg_write);
        end
        issue(BrIll, 1'b1, 1'b0);
        checks++;
        if ({a_illegal, a_mem_read, a_rd} !== {1'b1, 1'b0, 5'd0}) begin
            failures++;
            $display("FAIL load_f3_011 got ill=%b mr=%b rd=%0d want 1 0 0", a_illegal, a_mem_read, a_rd);
        end
        issue('0, 1'b0, 1'b0);
        checks++;
        if ({a_illegal, a_branch, a_valid} !== 3'b101) begin
            failures++;
            $display("FAIL branch_f3_010 got ill=%b br=%b v=%b want 1 0 1", a_illegal, a_branch, a_valid);
        end
    endtask

    initial begin
        test_reset();
        test_latency1();
        test_latency3();
        test_back_to_back();
        test_no_hazard();
        test_flush();
        test_reset_midstream();
        test_decode();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish by 200000");
        $fatal(1, "timeout");
    end

endmodule
